cam_ocram_writer: RTL and testbench

CAM_OCRAM_WRITER -- requirements
Module: cam_ocram_writer

---
 rtl/cam_ocram_pkg.sv | 15 +
 rtl/cam_pix_pack4.sv | 64 ++++++
 rtl/cam_ocram_writer.sv | 148 ++++++++++++++
 tb/tb_cam_ocram_writer.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_ocram_pkg.sv
// Shared constants and state type for the camera-to-OCRAM writer.
// Four RGB565 pixels pack into one 64-bit word of a 512-word ping-pong buffer.
package cam_ocram_pkg;

    localparam int PIX_PER_WORD = 4;
    localparam int HALF_WORDS   = 256;
    localparam int MEM_DEPTH    = 512;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PACK     = 2'd1,
        ST_WAIT_BUF = 2'd2
    } state_t;

endpackage

// File: rtl/cam_pix_pack4.sv
// Four-lane pixel packer: collects pixels into a word and emits it one
// cycle after the word completes or is flushed, with matching byte lanes.
module cam_pix_pack4
    import cam_ocram_pkg::*;
#(
    parameter int PIX_W = 16
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              push,
    input  logic                              flush,
    input  logic [PIX_W-1:0]                  pix,
    output logic                              word_last,
    output logic                              wr_valid,
    output logic [PIX_PER_WORD*PIX_W-1:0]     wr_data,
    output logic [PIX_PER_WORD*PIX_W/8-1:0]   wr_be
);

    localparam int CNT_W = $clog2(PIX_PER_WORD);
    localparam int LB    = PIX_W / 8;
    localparam int BE_W  = PIX_PER_WORD * LB;

    logic [PIX_PER_WORD-1:0][PIX_W-1:0] lanes;
    logic [PIX_PER_WORD-1:0][PIX_W-1:0] lanes_nx;
    logic [CNT_W-1:0]                   cnt;
    logic [BE_W-1:0]                    be_nx;

    always_comb begin
        lanes_nx      = lanes;
        lanes_nx[cnt] = pix;
        word_last     = push & (flush | (cnt == CNT_W'(PIX_PER_WORD - 1)));
        be_nx         = '0;
        for (int i = 0; i < PIX_PER_WORD; i++) begin
            if (CNT_W'(i) <= cnt) begin
                be_nx[i*LB +: LB] = '1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lanes    <= '0;
            cnt      <= '0;
            wr_valid <= 1'b0;
            wr_data  <= '0;
            wr_be    <= '0;
        end else begin
            wr_valid <= word_last;
            wr_data  <= word_last ? lanes_nx : '0;
            wr_be    <= word_last ? be_nx : '0;
            if (push) begin
                if (word_last) begin
                    // cleared lanes keep unused slots of a short word at zero
                    lanes <= '0;
                    cnt   <= '0;
                end else begin
                    lanes <= lanes_nx;
                    cnt   <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cam_ocram_writer.sv
// Camera pixel stream to ping-pong on-chip RAM writer with host-released
// halves, frame-aligned restart and mid-frame sop error flag.
module cam_ocram_writer #(
    parameter int PIX_W      = 16,
    parameter int ADDR_W     = 9,
    parameter int HALF_WORDS = 256
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [PIX_W-1:0]    pix_data,
    input  logic                pix_valid,
    input  logic                pix_sop,
    input  logic                pix_eop,
    output logic                pix_ready,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [PIX_W/2-1:0]  mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [4*PIX_W-1:0]  mem_writedata,
    output logic                half_done,
    output logic                half_id,
    output logic [ADDR_W-1:0]   half_words,
    output logic                half_eop,
    input  logic [1:0]          half_release,
    output logic                err_sop
);

    import cam_ocram_pkg::*;

    localparam int IDX_W = ADDR_W - 1;

    state_t           state;
    state_t           state_nx;
    logic             wait_eop;
    logic             wait_eop_nx;
    logic             fill;
    logic [IDX_W-1:0] widx;
    logic [1:0]       busy;
    logic [1:0]       busy_rel;
    logic [1:0]       busy_nx;
    logic [1:0]       rel_ok;
    logic             accept;
    logic             push;
    logic             flush;
    logic             word_last;
    logic             close;
    logic             wr_q;

    assign accept = pix_valid & pix_ready;
    assign push   = accept & ((state == ST_PACK) | pix_sop);
    assign flush  = push & pix_eop;
    assign close  = word_last & (pix_eop | (widx == IDX_W'(HALF_WORDS - 1)));

    assign mem_write      = wr_q;
    assign mem_chipselect = wr_q;

    cam_pix_pack4 #(
        .PIX_W (PIX_W)
    ) u_pack (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .flush     (flush),
        .pix       (pix_data),
        .word_last (word_last),
        .wr_valid  (wr_q),
        .wr_data   (mem_writedata),
        .wr_be     (mem_byteenable)
    );

    always_comb begin
        pix_ready = 1'b0;
        unique case (1'b1)
            (state == ST_IDLE): pix_ready = ~busy[fill];
            (state == ST_PACK): pix_ready = 1'b1;
            default:            pix_ready = 1'b0;
        endcase
    end

    // a release is dropped on its own half_done cycle or while filling
    always_comb begin
        rel_ok = '0;
        for (int h = 0; h < 2; h++) begin
            rel_ok[h] = half_release[h] & busy[h]
                      & ~(half_done & (half_id == 1'(h)))
                      & ~((state == ST_PACK) & (fill == 1'(h)));
        end
        busy_rel = busy & ~rel_ok;
        busy_nx  = busy_rel;
        if (close) begin
            busy_nx[fill] = 1'b1;
        end
    end

    always_comb begin
        state_nx    = state;
        wait_eop_nx = wait_eop;
        if (close) begin
            if (busy_rel[~fill]) begin
                state_nx    = ST_WAIT_BUF;
                wait_eop_nx = pix_eop;
            end else begin
                state_nx = pix_eop ? ST_IDLE : ST_PACK;
            end
        end else if (push && (state == ST_IDLE)) begin
            state_nx = ST_PACK;
        end else if ((state == ST_WAIT_BUF) && !busy[fill]) begin
            state_nx = wait_eop ? ST_IDLE : ST_PACK;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            wait_eop    <= 1'b0;
            fill        <= 1'b0;
            widx        <= '0;
            busy        <= '0;
            err_sop     <= 1'b0;
            mem_address <= '0;
            half_done   <= 1'b0;
            half_id     <= 1'b0;
            half_words  <= '0;
            half_eop    <= 1'b0;
        end else begin
            state       <= state_nx;
            wait_eop    <= wait_eop_nx;
            busy        <= busy_nx;
            mem_address <= word_last ? {fill, widx} : '0;
            half_done   <= close;
            half_id     <= close & fill;
            half_words  <= close ? ({1'b0, widx} + ADDR_W'(1)) : '0;
            half_eop    <= close & pix_eop;
            if (accept && pix_sop && (state == ST_PACK)) begin
                err_sop <= 1'b1;
            end
            if (word_last) begin
                if (close) begin
                    widx <= '0;
                    fill <= ~fill;
                end else begin
                    widx <= widx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cam_ocram_writer.sv
// Randomized bench for cam_ocram_writer against a frame-level pixel model.
module tb_cam_ocram_writer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] pix_data = '0;
    logic        pix_valid = 1'b0;
    logic        pix_sop = 1'b0;
    logic        pix_eop = 1'b0;
    logic        pix_ready;
    logic [8:0]  mem_address;
    logic [7:0]  mem_byteenable;
    logic        mem_chipselect;
    logic        mem_write;
    logic [63:0] mem_writedata;
    logic        half_done;
    logic        half_id;
    logic [8:0]  half_words;
    logic        half_eop;
    logic [1:0]  half_release = '0;
    logic        err_sop;

    always #5 clk = ~clk;

    cam_ocram_writer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .pix_data       (pix_data),
        .pix_valid      (pix_valid),
        .pix_sop        (pix_sop),
        .pix_eop        (pix_eop),
        .pix_ready      (pix_ready),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .half_done      (half_done),
        .half_id        (half_id),
        .half_words     (half_words),
        .half_eop       (half_eop),
        .half_release   (half_release),
        .err_sop        (err_sop)
    );

    int nchk = 0;
    int nerr = 0;

    // frame-level model: pixels in, words out
    bit          m_in_frame;
    logic [15:0] m_lanes[$];
    int          m_fill;
    int          m_widx;
    bit          m_err;

    bit          e_v, e_hd, e_heop;
    int          e_addr, e_hw, e_hid;
    logic [63:0] e_data;
    logic [7:0]  e_be;

    bit          acc;
    bit          auto_rel;
    int          rel_cnt[2];

    logic [8:0]  l_addr;
    logic [63:0] l_data;
    logic [7:0]  l_be;
    logic        l_hid, l_heop;
    logic [8:0]  l_hw;
    int          nwr, nhd;

    task automatic model_reset();
        m_in_frame = 0;
        m_lanes.delete();
        m_fill = 0;
        m_widx = 0;
        m_err = 0;
        rel_cnt[0] = 0;
        rel_cnt[1] = 0;
    endtask

    task automatic model_pix(input logic [15:0] d, input bit s, input bit e);
        if (!m_in_frame) begin
            if (!s) return;
            m_in_frame = 1;
        end else if (s) begin
            m_err = 1;
        end
        m_lanes.push_back(d);
        if (m_lanes.size() == 4 || e) begin
            e_v = 1;
            e_data = '0;
            foreach (m_lanes[k]) e_data = e_data | (64'(m_lanes[k]) << (16 * k));
            e_be = 8'((1 << (2 * m_lanes.size())) - 1);
            e_addr = m_fill * 256 + m_widx;
            e_hd = e || (m_widx == 255);
            e_hid = m_fill;
            e_hw = m_widx + 1;
            e_heop = e;
            if (e_hd) begin
                m_fill = 1 - m_fill;
                m_widx = 0;
            end else begin
                m_widx++;
            end
            if (e) m_in_frame = 0;
            m_lanes.delete();
        end
    endtask

    task automatic cyc(input bit v, input bit s, input bit e,
                       input logic [15:0] d, input logic [1:0] rel);
        logic [1:0] r;
        r = rel;
        for (int h = 0; h < 2; h++) begin
            if (rel_cnt[h] > 0) begin
                rel_cnt[h]--;
                if (rel_cnt[h] == 0) r[h] = 1'b1;
            end
        end
        pix_valid = v;
        pix_sop = s;
        pix_eop = e;
        pix_data = d;
        half_release = r;
        #1;
        acc = v && (pix_ready === 1'b1) && reset_n;
        e_v = 0;
        e_hd = 0;
        if (!reset_n) model_reset();
        else if (acc) model_pix(d, s, e);
        @(negedge clk);
        nchk++;
        if ({mem_write, mem_chipselect} !== {e_v, e_v}) begin
            nerr++;
            $display("FAIL wr_strobe: got %b want %b", {mem_write, mem_chipselect}, {e_v, e_v});
        end
        if (mem_write === 1'b1) begin
            l_addr = mem_address; l_data = mem_writedata; l_be = mem_byteenable;
            nwr++;
        end
        if (half_done === 1'b1) begin
            l_hid = half_id; l_hw = half_words; l_heop = half_eop;
            nhd++;
        end
        if (e_v) begin
            nchk++;
            if (mem_address !== 9'(e_addr)) begin
                nerr++;
                $display("FAIL wr_addr: got %0d want %0d", mem_address, e_addr);
            end
            nchk++;
            if (mem_writedata !== e_data || mem_byteenable !== e_be) begin
                nerr++;
                $display("FAIL wr_data: got %h/%h want %h/%h",
                         mem_writedata, mem_byteenable, e_data, e_be);
            end
            nchk++;
            if (half_done !== e_hd) begin
                nerr++;
                $display("FAIL half_done: got %b want %b", half_done, e_hd);
            end
            if (e_hd) begin
                nchk++;
                if (half_id !== 1'(e_hid) || half_words !== 9'(e_hw) || half_eop !== e_heop) begin
                    nerr++;
                    $display("FAIL half_info: got id%0d w%0d e%0d want id%0d w%0d e%0d",
                             half_id, half_words, half_eop, e_hid, e_hw, e_heop);
                end
            end
        end else begin
            nchk++;
            if (half_done !== 1'b0) begin
                nerr++;
                $display("FAIL half_done_idle: got %b want 0", half_done);
            end
        end
        nchk++;
        if (err_sop !== m_err) begin
            nerr++;
            $display("FAIL err_sop: got %b want %b", err_sop, m_err);
        end
        if (auto_rel && e_v && e_hd) rel_cnt[e_hid] = $urandom_range(2, 5);
    endtask

    task automatic send_pix(input logic [15:0] d, input bit s, input bit e, input int gap);
        bit done;
        done = 0;
        for (int c = 0; c < 64 && !done; c++) begin
            if (gap > 0 && $urandom_range(0, 99) < gap) begin
                cyc(1'b0, 1'b0, 1'b0, 16'h0, 2'b00);
            end else begin
                cyc(1'b1, s, e, d, 2'b00);
                done = acc;
            end
        end
        nchk++;
        if (!done) begin
            nerr++;
            $display("FAIL send_timeout: got ready=%b want pixel accepted", pix_ready);
        end
    endtask

    task automatic do_reset();
        auto_rel = 0;
        reset_n = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 2'b00);
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 2'b00);
        reset_n = 1'b1;
        nwr = 0;
        nhd = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        nchk++;
        if (pix_ready !== 1'b1 || mem_write !== 1'b0 || mem_chipselect !== 1'b0) begin
            nerr++;
            $display("FAIL %s_ctrl: got rdy%b wr%b cs%b want 1 0 0",
                     tag, pix_ready, mem_write, mem_chipselect);
        end
        nchk++;
        if (mem_address !== '0 || mem_byteenable !== '0 || mem_writedata !== '0) begin
            nerr++;
            $display("FAIL %s_bus: got %h %h %h want zeros",
                     tag, mem_address, mem_byteenable, mem_writedata);
        end
        nchk++;
        if ({half_done, half_id, half_eop, err_sop} !== 4'b0 || half_words !== '0) begin
            nerr++;
            $display("FAIL %s_half: got %b%b%b%b w%0d want zeros",
                     tag, half_done, half_id, half_eop, err_sop, half_words);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 2'b00);
        cyc(1'b1, 1'b1, 1'b0, 16'h1234, 2'b00);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        nwr = 0;
        nhd = 0;
    endtask

    task automatic test_two_words();
        do_reset();
        for (int i = 1; i <= 8; i++) send_pix(16'(i), i == 1, i == 8, 0);
        nchk++;
        if (nwr != 2 || l_addr !== 9'd1 || l_data !== 64'h0008000700060005 || l_be !== 8'hFF) begin
            nerr++;
            $display("FAIL two_words: got n%0d a%0d %h %h want n2 a1 0008000700060005 ff",
                     nwr, l_addr, l_data, l_be);
        end
        nchk++;
        if (nhd != 1 || l_hid !== 1'b0 || l_hw !== 9'd2 || l_heop !== 1'b1) begin
            nerr++;
            $display("FAIL two_words_half: got n%0d id%0d w%0d e%0d want 1 0 2 1",
                     nhd, l_hid, l_hw, l_heop);
        end
    endtask

    task automatic test_short_frame();
        do_reset();
        for (int i = 1; i <= 5; i++) send_pix(16'(i), i == 1, i == 5, 0);
        nchk++;
        if (l_addr !== 9'd1 || l_be !== 8'h03 || l_data !== 64'h5) begin
            nerr++;
            $display("FAIL short_tail: got a%0d %h %h want a1 03 5", l_addr, l_be, l_data);
        end
        for (int i = 0; i < 4; i++) send_pix(16'($urandom), i == 0, i == 3, 20);
        nchk++;
        if (l_addr !== 9'd256) begin
            nerr++;
            $display("FAIL next_frame_addr: got %0d want 256", l_addr);
        end
    endtask

    task automatic test_idle_discard();
        logic [15:0] p[4];
        do_reset();
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, i == 5, 16'($urandom), 2'b00);
        nchk++;
        if (nwr != 0) begin
            nerr++;
            $display("FAIL idle_discard: got %0d writes want 0", nwr);
        end
        foreach (p[i]) p[i] = 16'($urandom);
        for (int i = 0; i < 4; i++) send_pix(p[i], i == 0 || i == 2, i == 3, 0);
        nchk++;
        if (err_sop !== 1'b1 || l_data !== {p[3], p[2], p[1], p[0]}) begin
            nerr++;
            $display("FAIL mid_sop: got err%b %h want err1 %h",
                     err_sop, l_data, {p[3], p[2], p[1], p[0]});
        end
    endtask

    task automatic test_stream();
        int n, drops;
        logic [1:0] rel;
        bit seen, leak;
        do_reset();
        n = 0;
        drops = 0;
        rel = 2'b00;
        for (int c = 0; c < 2300 && n < 2048; c++) begin
            cyc(1'b1, n == 0, 1'b0, 16'($urandom), rel);
            rel = 2'b00;
            if (acc) n++; else drops++;
            // released on its own half_done cycle: must be ignored
            if (e_v && e_hd && e_hid == 0) rel = 2'b01;
        end
        nchk++;
        if (n != 2048 || drops != 0 || nwr != 512 || nhd != 2) begin
            nerr++;
            $display("FAIL stream: got px%0d drops%0d wr%0d hd%0d want 2048 0 512 2",
                     n, drops, nwr, nhd);
        end
        nchk++;
        if (pix_ready !== 1'b0) begin
            nerr++;
            $display("FAIL stall_ready: got %b want 0", pix_ready);
        end
        leak = 0;
        for (int c = 0; c < 4; c++) begin
            cyc(1'b1, 1'b0, 1'b0, 16'($urandom), 2'b00);
            leak |= acc;
        end
        nchk++;
        if (leak) begin
            nerr++;
            $display("FAIL stall_accept: got accepted want stalled");
        end
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 2'b01);
        seen = 0;
        for (int c = 0; c < 2 && !seen; c++) begin
            cyc(1'b0, 1'b0, 1'b0, 16'h0, 2'b00);
            seen = (pix_ready === 1'b1);
        end
        nchk++;
        if (!seen) begin
            nerr++;
            $display("FAIL release_ready: got %b want 1 within 2 cycles", pix_ready);
        end
        for (int i = 0; i < 4; i++) send_pix(16'($urandom), 1'b0, i == 3, 0);
        nchk++;
        if (l_addr !== 9'd0) begin
            nerr++;
            $display("FAIL after_release_addr: got %0d want 0", l_addr);
        end
    endtask

    task automatic test_eop_last_word();
        int n, drops;
        do_reset();
        n = 0;
        drops = 0;
        for (int c = 0; c < 1100 && n < 1024; c++) begin
            cyc(1'b1, n == 0, n == 1023, 16'($urandom), 2'b00);
            if (acc) n++; else drops++;
        end
        nchk++;
        if (n != 1024 || drops != 0 || nhd != 1) begin
            nerr++;
            $display("FAIL eop255_flow: got px%0d drops%0d hd%0d want 1024 0 1", n, drops, nhd);
        end
        nchk++;
        if (l_addr !== 9'd255 || l_hid !== 1'b0 || l_hw !== 9'd256 || l_heop !== 1'b1) begin
            nerr++;
            $display("FAIL eop255_half: got a%0d id%0d w%0d e%0d want 255 0 256 1",
                     l_addr, l_hid, l_hw, l_heop);
        end
        for (int i = 0; i < 4; i++) send_pix(16'($urandom), i == 0, i == 3, 0);
        nchk++;
        if (l_addr !== 9'd256) begin
            nerr++;
            $display("FAIL eop255_next: got %0d want 256", l_addr);
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        for (int i = 0; i < 3; i++) send_pix(16'($urandom), i == 0, 1'b0, 0);
        reset_n = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 2'b00);
        check_reset_outputs("midreset");
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 2'b00);
        reset_n = 1'b1;
        nchk++;
        if (nwr != 0) begin
            nerr++;
            $display("FAIL midreset_write: got %0d writes want 0", nwr);
        end
        for (int i = 0; i < 4; i++) send_pix(16'($urandom), i == 0, i == 3, 0);
        nchk++;
        if (nwr != 1 || l_addr !== 9'd0) begin
            nerr++;
            $display("FAIL midreset_next: got n%0d a%0d want 1 0", nwr, l_addr);
        end
    endtask

    task automatic test_random_frames();
        int len;
        do_reset();
        auto_rel = 1;
        for (int f = 0; f < 15; f++) begin
            for (int j = $urandom_range(0, 3); j > 0; j--)
                cyc(1'b1, 1'b0, 1'b0, 16'($urandom), 2'b00);
            len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++)
                send_pix(16'($urandom), i == 0 || $urandom_range(0, 49) == 0,
                         i == len - 1, 25);
        end
        for (int c = 0; c < 8; c++) cyc(1'b0, 1'b0, 1'b0, 16'h0, 2'b00);
        auto_rel = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_two_words();
        test_short_frame();
        test_idle_discard();
        test_stream();
        test_eop_last_word();
        test_reset_midframe();
        test_random_frames();
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
